// File: rtl/meta_pkg.sv
// Shared definitions for the tag-array metadata write responder.
// Widths and the request struct are fixed here; the top's parameters must match them.
package meta_pkg;

    localparam int unsigned NSETS = 64;
    localparam int unsigned NWAYS = 8;
    localparam int unsigned TAG_W = 20;
    localparam int unsigned IDX_W = $clog2(NSETS);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [NWAYS-1:0] way_en;
        logic [TAG_W-1:0] tag;
    } meta_req_t;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } meta_state_e;

endpackage

// File: rtl/meta_write_queue.sv
// Two-entry FIFO of pending metadata writes; slot0 is always the head.
// META_WRITE_BYPASS_EN exposes the second slot so reads can forward from it.
module meta_write_queue
    import meta_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       enq_valid,
    output logic       enq_ready,
    input  meta_req_t  enq_bits,
    output logic       deq_valid,
    input  logic       deq_ready,
    output meta_req_t  deq_bits,
`ifdef META_WRITE_BYPASS_EN
    output meta_req_t  tail_bits,
`endif
    output logic [1:0] count
);

    meta_req_t  slot0;
    meta_req_t  slot1;
    logic [1:0] cnt_q;
    logic       push;
    logic       pop;

    assign enq_ready = (cnt_q != 2'd2);
    assign deq_valid = (cnt_q != 2'd0);
    assign push      = enq_valid && enq_ready;
    assign pop       = deq_valid && deq_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Shift on pop, then land the push in the first free slot after the shift.
    always_ff @(posedge clock) begin
        if (pop) begin
            slot0 <= slot1;
        end
        if (push) begin
            if (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop)) begin
                slot0 <= enq_bits;
            end else begin
                slot1 <= enq_bits;
            end
        end
    end

    assign deq_bits  = slot0;
`ifdef META_WRITE_BYPASS_EN
    assign tail_bits = slot1;
`endif
    assign count     = cnt_q;

endmodule

// File: rtl/meta_write_responder.sv
// Tag array with a clearing sweep after reset, a 2-deep write queue and a 1-cycle read port.
// META_WRITE_BYPASS_EN forwards queued and in-flight writes into read responses.
module meta_write_responder
    import meta_pkg::meta_req_t, meta_pkg::meta_state_e, meta_pkg::ST_INIT, meta_pkg::ST_RUN;
#(
    parameter int unsigned NSETS = 64,
    parameter int unsigned NWAYS = 8,
    parameter int unsigned TAG_W = 20
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_in_valid,
    output logic                     io_in_ready,
    input  logic [$clog2(NSETS)-1:0] io_in_bits_idx,
    input  logic [NWAYS-1:0]         io_in_bits_way_en,
    input  logic [TAG_W-1:0]         io_in_bits_tag,
    input  logic                     io_read_valid,
    input  logic [$clog2(NSETS)-1:0] io_read_idx,
    output logic                     io_resp_valid,
    output logic [NWAYS*TAG_W-1:0]   io_resp_tags,
    output logic                     io_busy
);

    localparam int unsigned IDX_W = $clog2(NSETS);

    meta_state_e              state;
    logic [IDX_W-1:0]         sweep;
    logic [TAG_W-1:0]         tags [NSETS][NWAYS];

    logic                     running;
    logic                     q_enq_valid;
    logic                     q_enq_ready;
    logic                     q_deq_valid;
    logic                     q_deq_ready;
    meta_req_t                q_enq_bits;
    meta_req_t                q_head;
`ifdef META_WRITE_BYPASS_EN
    meta_req_t                q_tail;
`endif
    logic [1:0]               q_count;

    logic [NWAYS*TAG_W-1:0]   rd_tags;
    logic                     resp_valid_q;
    logic [NWAYS*TAG_W-1:0]   resp_tags_q;

    assign running     = (state == ST_RUN) && !reset;
    assign q_enq_valid = io_in_valid && running;
    assign q_deq_ready = running;
    assign io_in_ready = running && q_enq_ready;
    assign q_enq_bits  = '{idx: io_in_bits_idx, way_en: io_in_bits_way_en, tag: io_in_bits_tag};

    meta_write_queue u_queue (
        .clock     (clock),
        .reset     (reset),
        .enq_valid (q_enq_valid),
        .enq_ready (q_enq_ready),
        .enq_bits  (q_enq_bits),
        .deq_valid (q_deq_valid),
        .deq_ready (q_deq_ready),
        .deq_bits  (q_head),
`ifdef META_WRITE_BYPASS_EN
        .tail_bits (q_tail),
`endif
        .count     (q_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_INIT;
            sweep <= '0;
        end else if (state == ST_INIT) begin
            sweep <= sweep + 1'b1;
            if (sweep == IDX_W'(NSETS - 1)) begin
                state <= ST_RUN;
            end
        end
    end

    // Single write port: the clearing sweep owns it in INIT, the queue head in RUN.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == ST_INIT) begin
                for (int unsigned w = 0; w < NWAYS; w++) begin
                    tags[sweep][w] <= '0;
                end
            end else if (q_deq_valid) begin
                for (int unsigned w = 0; w < NWAYS; w++) begin
                    if (q_head.way_en[w]) begin
                        tags[q_head.idx][w] <= q_head.tag;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_tags = '0;
        for (int unsigned w = 0; w < NWAYS; w++) begin
            rd_tags[w*TAG_W +: TAG_W] = tags[io_read_idx][w];
`ifdef META_WRITE_BYPASS_EN
            // Oldest first: head (written this cycle), second slot, then the write being accepted.
            if (q_count != 2'd0 && q_head.idx == io_read_idx && q_head.way_en[w]) begin
                rd_tags[w*TAG_W +: TAG_W] = q_head.tag;
            end
            if (q_count == 2'd2 && q_tail.idx == io_read_idx && q_tail.way_en[w]) begin
                rd_tags[w*TAG_W +: TAG_W] = q_tail.tag;
            end
            if (q_enq_valid && q_enq_ready && q_enq_bits.idx == io_read_idx && q_enq_bits.way_en[w]) begin
                rd_tags[w*TAG_W +: TAG_W] = q_enq_bits.tag;
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
        end else begin
            resp_valid_q <= io_read_valid;
        end
        resp_tags_q <= rd_tags;
    end

    assign io_resp_valid = resp_valid_q && !reset;
    assign io_resp_tags  = resp_tags_q;
    assign io_busy       = reset || (state == ST_INIT) || (q_count != 2'd0);

endmodule

// File: tb/tb_meta_write_responder.sv
// Directed bench for meta_write_responder; read responses are checked by a scoreboard monitor.
// Expectations for same-cycle forwarding follow META_WRITE_BYPASS_EN.
module tb_meta_write_responder;

    logic         clock = 1'b0;
    logic         reset;
    logic         io_in_valid;
    logic         io_in_ready;
    logic [5:0]   io_in_bits_idx;
    logic [7:0]   io_in_bits_way_en;
    logic [19:0]  io_in_bits_tag;
    logic         io_read_valid;
    logic [5:0]   io_read_idx;
    logic         io_resp_valid;
    logic [159:0] io_resp_tags;
    logic         io_busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int           due;
        logic [159:0] tags;
        string        name;
    } exp_t;

    exp_t sbq[$];
    exp_t e_mon;

    always #5 clock = ~clock;

    meta_write_responder #(.NSETS(64), .NWAYS(8), .TAG_W(20)) dut (
        .clock             (clock),
        .reset             (reset),
        .io_in_valid       (io_in_valid),
        .io_in_ready       (io_in_ready),
        .io_in_bits_idx    (io_in_bits_idx),
        .io_in_bits_way_en (io_in_bits_way_en),
        .io_in_bits_tag    (io_in_bits_tag),
        .io_read_valid     (io_read_valid),
        .io_read_idx       (io_read_idx),
        .io_resp_valid     (io_resp_valid),
        .io_resp_tags      (io_resp_tags),
        .io_busy           (io_busy)
    );

    function automatic logic [159:0] mk(input int w, input logic [19:0] t);
        logic [159:0] v;
        v = '0;
        v[w*20 +: 20] = t;
        return v;
    endfunction

    initial forever begin
        @(posedge clock);
        cyc = cyc + 1;
    end

    // Monitor: a response is due exactly one cycle after its read was sampled.
    initial forever begin
        @(negedge clock);
        if (sbq.size() > 0 && sbq[0].due < cyc) begin
            e_mon = sbq.pop_front();
            checks++;
            failures++;
            $display("FAIL %s: response missed, due cycle %0d now %0d", e_mon.name, e_mon.due, cyc);
        end
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e_mon = sbq.pop_front();
            checks++;
            if (io_resp_valid !== 1'b1 || io_resp_tags !== e_mon.tags) begin
                failures++;
                $display("FAIL %s: got valid=%0b tags=%h, want valid=1 tags=%h",
                         e_mon.name, io_resp_valid, io_resp_tags, e_mon.tags);
            end
        end else if (io_resp_valid !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp: got valid=%0b at cycle %0d, want 0", io_resp_valid, cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_read(input logic [5:0] idx, input logic [159:0] exp, input string name);
        io_read_valid = 1'b1;
        io_read_idx   = idx;
        sbq.push_back('{due: cyc + 1, tags: exp, name: name});
    endtask

    task automatic do_read(input logic [5:0] idx, input logic [159:0] exp, input string name);
        expect_read(idx, exp, name);
        tick();
        io_read_valid = 1'b0;
    endtask

    // Leaves io_in_valid high so back-to-back callers keep the request stream continuous.
    task automatic do_write(input logic [5:0] idx, input logic [7:0] way, input logic [19:0] tag);
        bit got;
        got               = 1'b0;
        io_in_valid       = 1'b1;
        io_in_bits_idx    = idx;
        io_in_bits_way_en = way;
        io_in_bits_tag    = tag;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clock);
            if (io_in_ready === 1'b1) got = 1'b1;
            else tick();
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL write_accept: ready stayed low for idx %0d, want accepted", idx);
        end
        tick();
    endtask

    initial begin
        int c0;
        int low;
        reset             = 1'b1;
        io_in_valid       = 1'b0;
        io_in_bits_idx    = '0;
        io_in_bits_way_en = '0;
        io_in_bits_tag    = '0;
        io_read_valid     = 1'b0;
        io_read_idx       = '0;

        @(negedge clock);
        chk("reset_ready", {31'd0, io_in_ready}, 32'd0);
        chk("reset_busy", {31'd0, io_busy}, 32'd1);
        chk("reset_resp_valid", {31'd0, io_resp_valid}, 32'd0);
        repeat (3) tick();
        reset = 1'b0;

        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            chk("init_ready_low", {31'd0, io_in_ready}, 32'd0);
            if (i == 0) chk("init_busy", {31'd0, io_busy}, 32'd1);
            tick();
        end
        @(negedge clock);
        chk("run_ready_high", {31'd0, io_in_ready}, 32'd1);
        chk("run_idle_busy", {31'd0, io_busy}, 32'd0);
        tick();
        do_read(6'd63, '0, "init_set63");

        // Single write: visible to reads sampled two edges after acceptance.
        do_write(6'd5, 8'h04, 20'hABCDE);
        io_in_valid = 1'b0;
`ifdef META_WRITE_BYPASS_EN
        do_read(6'd5, mk(2, 20'hABCDE), "wr5_landing_cycle");
`else
        do_read(6'd5, '0, "wr5_landing_cycle");
`endif
        do_read(6'd5, mk(2, 20'hABCDE), "wr5_readback");

        // Read sampled on the same edge that accepts the write.
`ifdef META_WRITE_BYPASS_EN
        expect_read(6'd9, mk(0, 20'h11111), "wr9_accept_cycle");
`else
        expect_read(6'd9, '0, "wr9_accept_cycle");
`endif
        do_write(6'd9, 8'h01, 20'h11111);
        io_in_valid   = 1'b0;
        io_read_valid = 1'b0;
        tick();
        do_read(6'd9, mk(0, 20'h11111), "wr9_readback");

        // Three writes with valid held; the third overwrites way0 of the first.
        c0 = cyc;
        do_write(6'd12, 8'h01, 20'h000A1);
        do_write(6'd12, 8'h02, 20'h000A2);
        do_write(6'd12, 8'h01, 20'h000A3);
        io_in_valid = 1'b0;
        chk("b2b_accept_cycles", cyc - c0, 32'd3);
        @(negedge clock);
        chk("b2b_busy_pending", {31'd0, io_busy}, 32'd1);
        tick();
        @(negedge clock);
        chk("b2b_busy_drained", {31'd0, io_busy}, 32'd0);
        tick();
        do_read(6'd12, mk(0, 20'h000A3) | mk(1, 20'h000A2), "b2b_order");

        // Same set/way twice: newest must win, also when forwarded mid-stream.
        do_write(6'd3, 8'h80, 20'h00001);
`ifdef META_WRITE_BYPASS_EN
        expect_read(6'd3, mk(7, 20'h00002), "wr3_midstream");
`else
        expect_read(6'd3, '0, "wr3_midstream");
`endif
        do_write(6'd3, 8'h80, 20'h00002);
        io_in_valid   = 1'b0;
        io_read_valid = 1'b0;
        tick();
        do_read(6'd3, mk(7, 20'h00002), "wr3_final");

        // Reset with a write queued and a read in flight: both must vanish.
        io_read_valid = 1'b1;
        io_read_idx   = 6'd5;
        do_write(6'd0, 8'h01, 20'h22222);
        io_in_valid   = 1'b0;
        io_read_valid = 1'b0;
        reset         = 1'b1;
        @(negedge clock);
        chk("midreset_resp_valid", {31'd0, io_resp_valid}, 32'd0);
        chk("midreset_ready", {31'd0, io_in_ready}, 32'd0);
        chk("midreset_busy", {31'd0, io_busy}, 32'd1);
        tick();
        reset = 1'b0;
        do_read(6'd0, '0, "dropped_write_set0");
        do_read(6'd5, mk(2, 20'hABCDE), "sweep_restart_set5");
        low = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            if (io_in_ready === 1'b1) break;
            low++;
            tick();
        end
        chk("resweep_ready_low_cycles", low, 32'd62);
        tick();
        do_read(6'd5, '0, "resweep_set5_cleared");

        repeat (3) tick();
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
